// File: rtl/full_err_scale_pkg.sv
// Shared float_24_8 type and default sizing for the error-scaling block.
package full_err_scale_pkg;

    typedef struct packed {
        logic        sgn;
        logic [7:0]  exp;
        logic [22:0] man;
    } float_24_8;

    localparam int FLOAT_BIAS    = 127;
    localparam int FLUSH_EXP_DEF = 10;
    localparam int FRAME_LEN_DEF = 36;

endpackage

// File: rtl/full_err_fmul.sv
// Stallable float_24_8 multiplier with flush-to-zero, saturation and nearest-even rounding.
// Latency: 3 cycles (operand capture, mantissa product, normalise/round into output regs).
// Backpressure: all three stages advance only when en is high, otherwise everything holds.
module full_err_fmul
    import full_err_scale_pkg::*;
#(
    parameter int FLUSH_EXP = FLUSH_EXP_DEF
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      en,
    input  logic      in_vld,
    input  logic      in_fst,
    input  float_24_8 a,
    input  float_24_8 b,
    output logic      s1_vld,
    output logic      s2_vld,
    output logic      out_vld,
    output logic      out_fst,
    output float_24_8 out
);

    localparam logic [7:0]         FLUSH_E = 8'(FLUSH_EXP);
    localparam logic signed [10:0] FLUSH_S = 11'(FLUSH_EXP);

    logic        s1_sgn, s1_zero, s1_fst;
    logic [9:0]  s1_esum;
    logic [23:0] s1_ma, s1_mb;

    logic        s2_sgn, s2_zero, s2_fst;
    logic [9:0]  s2_esum;
    logic [47:0] s2_p;

    logic [23:0]        rnd_man;
    logic signed [10:0] e_norm, e_fin;
    float_24_8          res;

    always_ff @(posedge clk) begin
        if (en) begin
            s1_sgn  <= a.sgn ^ b.sgn;
            s1_esum <= {2'b00, a.exp} + {2'b00, b.exp};
            s1_zero <= (a.exp < FLUSH_E) || (b.exp < FLUSH_E);
            s1_ma   <= {1'b1, a.man};
            s1_mb   <= {1'b1, b.man};
            s1_fst  <= in_fst;
            s2_sgn  <= s1_sgn;
            s2_esum <= s1_esum;
            s2_zero <= s1_zero;
            s2_p    <= s1_ma * s1_mb;
            s2_fst  <= s1_fst;
        end
    end

    // Guard/sticky/lsb rounding; a carry out of the mantissa bumps the exponent.
    always_comb begin
        if (s2_p[47]) begin
            rnd_man = {1'b0, s2_p[46:24]} + 24'(s2_p[23] & ((|s2_p[22:0]) | s2_p[24]));
            e_norm  = $signed({1'b0, s2_esum}) - 11'sd126;
        end else begin
            rnd_man = {1'b0, s2_p[45:23]} + 24'(s2_p[22] & ((|s2_p[21:0]) | s2_p[23]));
            e_norm  = $signed({1'b0, s2_esum}) - 11'sd127;
        end
        e_fin = rnd_man[23] ? e_norm + 11'sd1 : e_norm;
        res   = '0;
        if (s2_zero || (e_fin < FLUSH_S)) begin
            res = '0;
        end else if (e_fin > 11'sd254) begin
            res = {s2_sgn, 8'd254, 23'h7FFFFF};
        end else begin
            res = {s2_sgn, e_fin[7:0], rnd_man[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            out_vld <= 1'b0;
            out_fst <= 1'b0;
            out     <= '0;
        end else if (en) begin
            s1_vld  <= in_vld;
            s2_vld  <= s1_vld;
            out_vld <= s2_vld;
            out_fst <= s2_vld & s2_fst;
            out     <= s2_vld ? res : '0;
        end
    end

endmodule

// File: rtl/full_err_scale.sv
// Scales output-error samples by a learning rate and tracks frame length (FULL_ERR_SCALE_STATS_EN adds err_max_exp).
// Latency: 3 cycles accept-to-delta_vld, 1 sample/cycle.
// Backpressure: zctrl_rdy drops while a delta is held unaccepted; the whole pipeline freezes.
module full_err_scale
    import full_err_scale_pkg::*;
#(
    parameter int          FRAME_LEN  = FRAME_LEN_DEF,
    parameter int          FLUSH_EXP  = FLUSH_EXP_DEF,
    parameter logic [31:0] RATE_RESET = 32'h3C23D70A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] zctrl,
    input  logic        zctrl_fst,
    input  logic        zctrl_vld,
    output logic        zctrl_rdy,
    input  logic [31:0] rate,
    input  logic        rate_ld,
    output logic [31:0] delta,
    output logic        delta_fst,
    output logic        delta_vld,
    input  logic        delta_rdy,
    output logic        frame_err,
`ifdef FULL_ERR_SCALE_STATS_EN
    output logic [7:0]  err_max_exp,
`endif
    output logic [5:0]  frame_cnt
);

    localparam logic [5:0] FLEN = 6'(FRAME_LEN);

    logic        en, accept, busy, s1_vld, s2_vld;
    logic [31:0] rate_q;
    float_24_8   zin, op_rate, out_f;

    assign zin       = float_24_8'(zctrl);
    assign en        = ~(delta_vld & ~delta_rdy);
    assign zctrl_rdy = en;
    assign accept    = zctrl_vld & zctrl_rdy;
    assign busy      = s1_vld | s2_vld | delta_vld;
    // A frame's first beat already multiplies by the rate it brings with it.
    assign op_rate   = float_24_8'(zctrl_fst ? rate : rate_q);
    assign delta     = 32'(out_f);

    full_err_fmul #(.FLUSH_EXP(FLUSH_EXP)) u_fmul (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .in_vld  (accept),
        .in_fst  (zctrl_fst),
        .a       (zin),
        .b       (op_rate),
        .s1_vld  (s1_vld),
        .s2_vld  (s2_vld),
        .out_vld (delta_vld),
        .out_fst (delta_fst),
        .out     (out_f)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rate_q    <= RATE_RESET;
            frame_cnt <= '0;
            frame_err <= 1'b0;
        end else begin
            if (accept && zctrl_fst) begin
                rate_q <= rate;
            end else if (rate_ld && !busy && !accept) begin
                rate_q <= rate;
            end
            if (accept) begin
                if (zctrl_fst) begin
                    if (frame_cnt != 6'd0 && frame_cnt != FLEN) frame_err <= 1'b1;
                    frame_cnt <= 6'd1;
                end else if (frame_cnt >= FLEN) begin
                    frame_err <= 1'b1;
                    frame_cnt <= FLEN;
                end else begin
                    frame_cnt <= frame_cnt + 6'd1;
                end
            end
        end
    end

`ifdef FULL_ERR_SCALE_STATS_EN
    logic [7:0] run_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            run_max     <= '0;
            err_max_exp <= '0;
        end else if (accept) begin
            if (zctrl_fst) begin
                err_max_exp <= run_max;
                run_max     <= zin.exp;
            end else if (zin.exp > run_max) begin
                run_max <= zin.exp;
            end
        end
    end
`endif

endmodule
